// File: rtl/enc_pkg.sv
// Shared encoder/decoder package: default vector width, index-width derivation
// and the sequential encoder state type.
package enc_pkg;

  localparam int WIDTH_DEFAULT = 8;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

  localparam int IDX_W_DEFAULT = idx_w(WIDTH_DEFAULT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Request-in / index-out handshake bundle for seq_priority_encoder.
interface seq_priority_encoder_if
  import enc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  localparam int IDX_W = idx_w(WIDTH);

  // Both channels use valid/ready: a transfer happens on a rising clock edge
  // where valid and ready are both high; the source holds valid and payload
  // stable until that edge, and ready may depend on nothing from the source.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] data_out;
  logic             out_last;

  // Environment side: produces vectors, consumes indices.
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last
  );

  // Encoder side.
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last
  );

endinterface

// File: rtl/prio_find.sv
// Combinational fixed-priority search over a request vector. Defining
// SEQ_PRIO_ENC_MSB_FIRST_EN selects the highest set bit; otherwise the lowest.
module prio_find
  import enc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vector,
  output logic [IDX_W-1:0] idx,
  output logic             one_left
);

  always_comb begin
    idx = '0;
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < WIDTH; i++) begin
      if (vector[i]) idx = IDX_W'(i);
    end
`else
    // Descending scan: the last hit is the lowest set bit.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vector[i]) idx = IDX_W'(i);
    end
`endif
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign one_left = (vector != '0) && ((vector & (vector - WIDTH'(1))) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: accepts a multi-hot vector and emits one index
// per output handshake. Order set by SEQ_PRIO_ENC_MSB_FIRST_EN (default LSB-first).
module seq_priority_encoder
  import enc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_priority_encoder_if.slave bus,
  output logic                  busy,
  output enc_state_e            state_dbg
);

  enc_state_e       state, state_nxt;
  logic [WIDTH-1:0] pending, pending_nxt;
  logic [IDX_W-1:0] find_idx;
  logic             one_left;
  logic [WIDTH-1:0] sel_mask;

  logic             in_ready_c;
  logic             out_valid_c;
  logic [IDX_W-1:0] data_out_c;
  logic             out_last_c;

  prio_find #(.WIDTH(WIDTH)) u_prio_find (
    .vector   (pending),
    .idx      (find_idx),
    .one_left (one_left)
  );

  assign sel_mask = {{(WIDTH-1){1'b0}}, 1'b1} << find_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Outputs depend only on state and pending, so no input reaches an output
  // combinationally; the last handshake returns to IDLE before a new accept.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    data_out_c  = '0;
    out_last_c  = 1'b0;
    busy        = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          pending_nxt = bus.data_in;
          if (bus.data_in != '0) state_nxt = EMIT;
        end
      end
      EMIT: begin
        busy        = 1'b1;
        out_valid_c = 1'b1;
        data_out_c  = find_idx;
        out_last_c  = one_left;
        if (bus.out_ready) begin
          pending_nxt = pending & ~sel_mask;
          if (one_left) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.data_out  = data_out_c;
  assign bus.out_last  = out_last_c;
  assign state_dbg     = state;

  // Stalled output must not change, and EMIT never runs on an empty vector.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_c && !bus.out_ready) |=> (out_valid_c && $stable(data_out_c) && $stable(out_last_c)));

  a_emit_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EMIT) |-> (pending != '0));

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder; expected index orders follow
// SEQ_PRIO_ENC_MSB_FIRST_EN when it is defined for the build.
module tb_seq_priority_encoder;
  import enc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       busy;
  enc_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  seq_priority_encoder_if #(.WIDTH(8)) bus ();

  seq_priority_encoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one vector at a negedge; it is accepted at the following posedge.
  task automatic send_vec(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.data_in  = v;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.data_out, bus.out_last, busy} !== 7'b1_0_000_0_0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b dout=%0d last=%b busy=%b expected 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.data_out, bus.out_last, busy);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected IDLE", state_dbg);
    end
  endtask

  task automatic test_single;
    bus.out_ready = 1'b1;
    send_vec(8'b0000_0001);
    checks++;
    if ({bus.out_valid, bus.data_out, bus.out_last, busy, bus.in_ready} !== 7'b1_000_1_1_0) begin
      errors++;
      $display("FAIL single_out: got vld=%b dout=%0d last=%b busy=%b rdy=%b expected 1 0 1 1 0",
               bus.out_valid, bus.data_out, bus.out_last, busy, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b1_0_0) begin
      errors++;
      $display("FAIL single_after: got rdy=%b vld=%b busy=%b expected 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_multi_hot;
    logic [2:0] exp_q[$];
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
    exp_q = '{3'd7, 3'd5, 3'd2};
`else
    exp_q = '{3'd2, 3'd5, 3'd7};
`endif
    bus.out_ready = 1'b1;
    send_vec(8'b1010_0100);
    while (exp_q.size() != 0) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== exp_q[0] ||
          bus.out_last !== (exp_q.size() == 1)) begin
        errors++;
        $display("FAIL multi_idx: got vld=%b dout=%0d last=%b expected 1 %0d %b",
                 bus.out_valid, bus.data_out, bus.out_last, exp_q[0], exp_q.size() == 1);
      end
      void'(exp_q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_done: got vld=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [2:0] exp_q[$];
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
    exp_q = '{3'd7, 3'd5, 3'd2};
`else
    exp_q = '{3'd2, 3'd5, 3'd7};
`endif
    bus.out_ready = 1'b0;
    send_vec(8'b1010_0100);
    repeat (3) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== exp_q[0] || bus.out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got vld=%b dout=%0d last=%b expected 1 %0d 0",
                 bus.out_valid, bus.data_out, bus.out_last, exp_q[0]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== exp_q[0] ||
          bus.out_last !== (exp_q.size() == 1)) begin
        errors++;
        $display("FAIL bp_release: got vld=%b dout=%0d last=%b expected 1 %0d %b",
                 bus.out_valid, bus.data_out, bus.out_last, exp_q[0], exp_q.size() == 1);
      end
      void'(exp_q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got vld=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_zero_vector;
    bus.out_ready = 1'b1;
    send_vec(8'h00);
    repeat (3) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_vec: got vld=%b rdy=%b busy=%b expected 0 1 0",
                 bus.out_valid, bus.in_ready, busy);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // All bits set, with a different vector offered while busy that must be ignored.
  task automatic test_all_ones;
    logic [2:0] exp_q[$];
    int         hs;
    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
      exp_q.push_back(3'(7 - i));
`else
      exp_q.push_back(3'(i));
`endif
    end
    hs = 0;
    bus.out_ready = 1'b1;
    send_vec(8'hFF);
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h18;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.out_valid === 1'b1) begin
        hs++;
        checks++;
        if (exp_q.size() == 0 || bus.data_out !== exp_q[0] ||
            bus.out_last !== (exp_q.size() == 1)) begin
          errors++;
          $display("FAIL ff_idx: got dout=%0d last=%b at handshake %0d", bus.data_out, bus.out_last, hs);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (cyc == 7) bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (hs !== 8) begin
      errors++;
      $display("FAIL ff_count: got %0d handshakes expected 8", hs);
    end
  endtask

  task automatic test_reset_mid_emit;
    bus.out_ready = 1'b1;
    send_vec(8'b1010_0100);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 3'd5) begin
      errors++;
      $display("FAIL rst_pre: got vld=%b dout=%0d expected 1 5", bus.out_valid, bus.data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, busy, bus.in_ready, bus.data_out, bus.out_last} !== 7'b0_0_1_000_0) begin
      errors++;
      $display("FAIL rst_async: got vld=%b busy=%b rdy=%b dout=%0d last=%b expected 0 0 1 0 0",
               bus.out_valid, busy, bus.in_ready, bus.data_out, bus.out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_after: got vld=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_hot();
    test_backpressure();
    test_zero_vector();
    test_all_ones();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
